// File: rtl/regbank_pkg.sv
// Shared register-bank geometry and the address/data types used by the writeback path.
package regbank_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned REG_DW    = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

endpackage

// File: rtl/regbank_write_arbiter_if.sv
// Writeback request bus from the sources plus the bank write port driven by the arbiter.
interface regbank_write_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = regbank_pkg::REG_AW,
  parameter int unsigned DW   = regbank_pkg::REG_DW
);
  localparam int unsigned IW = $clog2(NREQ);

  logic               stall;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               write;
  logic [AW-1:0]      dr;
  logic [DW-1:0]      wrdata;
  logic [IW-1:0]      grant_id;
  logic [15:0]        write_count;

  // Sources and bank side.
  modport master (
    output stall, req_valid, req_addr, req_data,
    input  req_ready, write, dr, wrdata, grant_id, write_count
  );

  // Arbiter side.
  modport slave (
    input  stall, req_valid, req_addr, req_data,
    output req_ready, write, dr, wrdata, grant_id, write_count
  );

endinterface

// File: rtl/regbank_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_picker #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic        found;
  int unsigned pos;

  assign any = |req;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = (32'(ptr) + k) % NREQ;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter for the register bank's single write port, one registered write per cycle.
// Optional ZERO_REG_DROP_EN: accept writes to register 0 but never issue them to the bank.
module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = REG_AW,
  parameter int unsigned DW   = REG_DW
) (
  input logic                   clock,
  input logic                   reset,
  regbank_write_arbiter_if.slave bus
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [IW-1:0]   ptr_q;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   win;
  logic            any;
  logic            xfer;
  logic            wr_en_d;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  logic            write_q;
  logic [AW-1:0]   dr_q;
  logic [DW-1:0]   wrdata_q;
  logic [IW-1:0]   grant_id_q;
  logic [15:0]     write_count_q;

  rr_picker #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_picker (
    .req  (bus.req_valid),
    .ptr  (ptr_q),
    .grant(grant),
    .idx  (win),
    .any  (any)
  );

  assign xfer          = any && !bus.stall && !reset;
  assign bus.req_ready = xfer ? grant : '0;
  assign win_addr      = bus.req_addr[win*AW +: AW];
  assign win_data      = bus.req_data[win*DW +: DW];

`ifdef ZERO_REG_DROP_EN
  assign wr_en_d = xfer && (win_addr != '0);
`else
  assign wr_en_d = xfer;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q         <= '0;
      write_q       <= 1'b0;
      dr_q          <= '0;
      wrdata_q      <= '0;
      grant_id_q    <= '0;
      write_count_q <= '0;
    end else begin
      write_q <= wr_en_d;
      if (xfer) begin
        ptr_q      <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
        dr_q       <= win_addr;
        wrdata_q   <= win_data;
        grant_id_q <= win;
      end
      if (wr_en_d && (write_count_q != 16'hFFFF)) begin
        write_count_q <= write_count_q + 16'd1;
      end
    end
  end

  assign bus.write       = write_q;
  assign bus.dr          = dr_q;
  assign bus.wrdata      = wrdata_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.write_count = write_count_q;

endmodule
